// File: rtl/lyr2_seq.sv
// Layer-2 neuron sequencer: walks the weight/bias memory once per run and
// steers operands into an external 2-input MAC, writing one result per neuron.
module lyr2_seq #(
    parameter int N_OUT = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   d1_in,
    input  logic [15:0]   d2_in,
    output logic [AW-1:0] wb_addr,
    input  logic [15:0]   wb_w1,
    input  logic [15:0]   wb_w2,
    input  logic [15:0]   wb_b,
    output logic [15:0]   mac_d1,
    output logic [15:0]   mac_d2,
    output logic [15:0]   mac_w1,
    output logic [15:0]   mac_w2,
    output logic [15:0]   mac_b,
    input  logic [15:0]   mac_res,
    output logic          out_we,
    output logic [AW-1:0] out_addr,
    output logic [15:0]   out_data,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Explicit terminal compare so N_OUT = 2^AW never depends on wrap-around.
    localparam logic [AW-1:0] LAST = AW'(N_OUT - 1);

    state_t        state;
    state_t        state_nx;
    logic          drain_cnt;
    logic          wr_vld;
    logic [AW-1:0] wr_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (wb_addr == LAST) state_nx = DRAIN;
            DRAIN:   if (drain_cnt) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Two-stage write pipeline: address issued in C(i+1), data in C(i+2),
    // registered products plus delayed bias give the result in C(i+3).
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_addr   <= '0;
            mac_d1    <= '0;
            mac_d2    <= '0;
            mac_b     <= '0;
            drain_cnt <= 1'b0;
            wr_vld    <= 1'b0;
            wr_addr   <= '0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy      <= (state_nx == RUN) || (state_nx == DRAIN);
            done      <= (state_nx == DONE);
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            mac_b     <= wb_b;
            wr_vld    <= (state == RUN);
            wr_addr   <= wb_addr;
            out_we    <= wr_vld;
            if (wr_vld) begin
                out_addr <= wr_addr;
            end
            if (state == IDLE && start) begin
                mac_d1  <= d1_in;
                mac_d2  <= d2_in;
                wb_addr <= '0;
            end else if (state == RUN && wb_addr != LAST) begin
                wb_addr <= wb_addr + 1'b1;
            end
        end
    end

    assign mac_w1   = wb_w1;
    assign mac_w2   = wb_w2;
    assign out_data = mac_res;

endmodule

// File: tb/tb_lyr2_seq.sv
// Directed bench for lyr2_seq: N_OUT=8 and N_OUT=1 instances, each with a
// synchronous memory model and a Q8.8 MAC model (registered products, comb bias add).
module tb_lyr2_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start1;
    logic [15:0] d1;
    logic [15:0] d2;

    int tests;
    int failed;

    // ---------------- N_OUT = 8 instance ----------------
    logic [2:0]  wb_addr8;
    logic [15:0] rw1_8, rw2_8, rb_8;
    logic [15:0] md1_8, md2_8, mw1_8, mw2_8, mb_8, res_8, od_8;
    logic [15:0] p1_8, p2_8;
    logic        we_8, busy_8, done_8;
    logic [2:0]  oa_8;

    lyr2_seq #(.N_OUT(8), .AW(3)) dut8 (
        .clk(clk), .rst(rst), .start(start), .d1_in(d1), .d2_in(d2),
        .wb_addr(wb_addr8), .wb_w1(rw1_8), .wb_w2(rw2_8), .wb_b(rb_8),
        .mac_d1(md1_8), .mac_d2(md2_8), .mac_w1(mw1_8), .mac_w2(mw2_8), .mac_b(mb_8),
        .mac_res(res_8), .out_we(we_8), .out_addr(oa_8), .out_data(od_8),
        .busy(busy_8), .done(done_8)
    );

    always_ff @(posedge clk) begin
        rw1_8 <= 16'h0100 + {13'h0, wb_addr8};
        rw2_8 <= 16'h0200 + {13'h0, wb_addr8};
        rb_8  <= 16'h1000 + {13'h0, wb_addr8};
        p1_8  <= 16'(({16'h0, md1_8} * {16'h0, mw1_8}) >> 8);
        p2_8  <= 16'(({16'h0, md2_8} * {16'h0, mw2_8}) >> 8);
    end
    assign res_8 = p1_8 + p2_8 + mb_8;

    // ---------------- N_OUT = 1 instance ----------------
    logic [2:0]  wb_addr1;
    logic [15:0] rw1_1, rw2_1, rb_1;
    logic [15:0] md1_1, md2_1, mw1_1, mw2_1, mb_1, res_1, od_1;
    logic [15:0] p1_1, p2_1;
    logic        we_1, busy_1, done_1;
    logic [2:0]  oa_1;

    lyr2_seq #(.N_OUT(1), .AW(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .d1_in(d1), .d2_in(d2),
        .wb_addr(wb_addr1), .wb_w1(rw1_1), .wb_w2(rw2_1), .wb_b(rb_1),
        .mac_d1(md1_1), .mac_d2(md2_1), .mac_w1(mw1_1), .mac_w2(mw2_1), .mac_b(mb_1),
        .mac_res(res_1), .out_we(we_1), .out_addr(oa_1), .out_data(od_1),
        .busy(busy_1), .done(done_1)
    );

    always_ff @(posedge clk) begin
        rw1_1 <= 16'h0100 + {13'h0, wb_addr1};
        rw2_1 <= 16'h0200 + {13'h0, wb_addr1};
        rb_1  <= 16'h1000 + {13'h0, wb_addr1};
        p1_1  <= 16'(({16'h0, md1_1} * {16'h0, mw1_1}) >> 8);
        p2_1  <= 16'(({16'h0, md2_1} * {16'h0, mw2_1}) >> 8);
    end
    assign res_1 = p1_1 + p2_1 + mb_1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; start1 = 1'b1; d1 = 16'h1234; d2 = 16'h5678;
        repeat (3) @(negedge clk);
        tests++; if (busy_8 !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy_8); end
        tests++; if (done_8 !== 1'b0) begin failed++; $display("FAIL reset_done got %b exp 0", done_8); end
        tests++; if (we_8 !== 1'b0) begin failed++; $display("FAIL reset_we got %b exp 0", we_8); end
        tests++; if (wb_addr8 !== 3'd0) begin failed++; $display("FAIL reset_wb_addr got %0d exp 0", wb_addr8); end
        tests++; if (oa_8 !== 3'd0) begin failed++; $display("FAIL reset_out_addr got %0d exp 0", oa_8); end
        tests++; if (md1_8 !== 16'h0 || md2_8 !== 16'h0) begin failed++; $display("FAIL reset_mac_d got %h/%h exp 0/0", md1_8, md2_8); end
        tests++; if (mb_8 !== 16'h0) begin failed++; $display("FAIL reset_mac_b got %h exp 0", mb_8); end
        tests++; if (busy_1 !== 1'b0) begin failed++; $display("FAIL reset_busy1 got %b exp 0", busy_1); end
        start = 1'b0; start1 = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (busy_8 !== 1'b0) begin failed++; $display("FAIL reset_release_idle got %b exp 0", busy_8); end
    endtask

    // Full per-cycle check of one N_OUT=8 run; optionally pulses start in C5.
    task automatic test_nominal(input bit pulse_c5);
        logic [2:0]  e_addr;
        logic [15:0] e_data;
        logic        e_we;
        @(negedge clk); d1 = 16'h0100; d2 = 16'h0080; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; d1 = 16'hdead; d2 = 16'hbeef;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            e_addr = (k <= 8) ? 3'(k - 1) : 3'd7;
            e_we   = (k >= 3 && k <= 10);
            e_data = 16'h1200 + 16'(2 * (k - 3)) + 16'((k - 3) >> 1);
            tests++; if (wb_addr8 !== e_addr) begin failed++; $display("FAIL wb_addr C%0d got %0d exp %0d", k, wb_addr8, e_addr); end
            tests++; if (md1_8 !== 16'h0100 || md2_8 !== 16'h0080) begin failed++; $display("FAIL mac_d C%0d got %h/%h exp 0100/0080", k, md1_8, md2_8); end
            tests++; if (we_8 !== e_we) begin failed++; $display("FAIL out_we C%0d got %b exp %b", k, we_8, e_we); end
            if (e_we) begin
                tests++; if (oa_8 !== 3'(k - 3)) begin failed++; $display("FAIL out_addr C%0d got %0d exp %0d", k, oa_8, k - 3); end
                tests++; if (mb_8 !== 16'h1000 + 16'(k - 3)) begin failed++; $display("FAIL mac_b C%0d got %h exp %h", k, mb_8, 16'h1000 + 16'(k - 3)); end
                tests++; if (od_8 !== e_data) begin failed++; $display("FAIL out_data C%0d got %h exp %h", k, od_8, e_data); end
            end
            tests++; if (busy_8 !== (k >= 1 && k <= 10)) begin failed++; $display("FAIL busy C%0d got %b exp %b", k, busy_8, (k <= 10)); end
            tests++; if (done_8 !== (k == 11)) begin failed++; $display("FAIL done C%0d got %b exp %b", k, done_8, (k == 11)); end
            if (pulse_c5 && k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int m;
        @(negedge clk); d1 = 16'h0100; d2 = 16'h0080; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            m = (k <= 35) ? (k % 12) : 0;
            tests++; if (we_8 !== (m >= 3 && m <= 10)) begin failed++; $display("FAIL b2b_we C%0d got %b exp %b", k, we_8, (m >= 3 && m <= 10)); end
            if (m >= 3 && m <= 10) begin
                tests++; if (oa_8 !== 3'(m - 3) || od_8 !== 16'h1200 + 16'(2 * (m - 3)) + 16'((m - 3) >> 1)) begin
                    failed++; $display("FAIL b2b_write C%0d got %0d/%h exp %0d", k, oa_8, od_8, m - 3); end
            end
            tests++; if (busy_8 !== (m >= 1 && m <= 10)) begin failed++; $display("FAIL b2b_busy C%0d got %b", k, busy_8); end
            tests++; if (done_8 !== (m == 11)) begin failed++; $display("FAIL b2b_done C%0d got %b", k, done_8); end
            if (k == 29) start = 1'b0;
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk); d1 = 16'h0100; d2 = 16'h0080; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tests++; if (busy_8 !== 1'b0 || we_8 !== 1'b0 || done_8 !== 1'b0) begin
            failed++; $display("FAIL midrst_ctrl got busy=%b we=%b done=%b exp 0", busy_8, we_8, done_8); end
        tests++; if (wb_addr8 !== 3'd0 || oa_8 !== 3'd0) begin failed++; $display("FAIL midrst_addr got %0d/%0d exp 0/0", wb_addr8, oa_8); end
        tests++; if (md1_8 !== 16'h0 || md2_8 !== 16'h0 || mb_8 !== 16'h0) begin
            failed++; $display("FAIL midrst_operands got %h/%h/%h exp 0", md1_8, md2_8, mb_8); end
        for (int k = 7; k <= 18; k++) begin
            @(negedge clk);
            tests++; if (we_8 !== 1'b0 || done_8 !== 1'b0 || busy_8 !== 1'b0) begin
                failed++; $display("FAIL midrst_quiet C%0d got we=%b done=%b busy=%b exp 0", k, we_8, done_8, busy_8); end
        end
    endtask

    task automatic test_n1();
        @(negedge clk); d1 = 16'h0100; d2 = 16'h0080; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            tests++; if (wb_addr1 !== 3'd0) begin failed++; $display("FAIL n1_wb_addr C%0d got %0d exp 0", k, wb_addr1); end
            tests++; if (we_1 !== (k == 3)) begin failed++; $display("FAIL n1_we C%0d got %b exp %b", k, we_1, (k == 3)); end
            if (k == 3) begin
                tests++; if (oa_1 !== 3'd0 || od_1 !== 16'h1200) begin failed++; $display("FAIL n1_write got %0d/%h exp 0/1200", oa_1, od_1); end
            end
            tests++; if (busy_1 !== (k <= 3)) begin failed++; $display("FAIL n1_busy C%0d got %b exp %b", k, busy_1, (k <= 3)); end
            tests++; if (done_1 !== (k == 4)) begin failed++; $display("FAIL n1_done C%0d got %b exp %b", k, done_1, (k == 4)); end
        end
    endtask

    initial begin
        tests = 0; failed = 0;
        rst = 1'b0; start = 1'b0; start1 = 1'b0; d1 = '0; d2 = '0;
        test_reset();
        test_nominal(1'b0);
        test_nominal(1'b1);
        test_back_to_back();
        test_reset_midrun();
        test_nominal(1'b0);
        test_n1();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
